text_grid_buffer: RTL and testbench
===================================

Name: text_grid_buffer

Overview:
Parametrised character-cell text buffer for the VGA text path. It is a dual-ported store of character codes, indexed by logical row/column. A hardware clear engine and a one-row scroll engine run as a small FSM. It takes the dot/scanline counters from the timing generator and delivers a registered character code plus a blinking-cursor flag to the glyph generator.

Parameters:
COLS, 100, character columns per row
ROWS, 37, character rows
CHAR_W, 4, character code width in bits
CELL_W, 8, cell width in pixels (power of 2)
CELL_H, 16, cell height in scanlines (power of 2)
FILL_CHAR, 0, code written by clear/scroll
BLINK_DIV, 24, cursor blink phase = bit BLINK_DIV-1 of free-running clk counter

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
wr_valid  in  1  write request
wr_ready  out  1  write accepted when wr_valid & wr_ready
wr_col  in  $clog2(COLS)  logical column
wr_row  in  $clog2(ROWS)  logical row
wr_char  in  CHAR_W  code to store
clear_req  in  1  one-cycle pulse: clear whole screen
scroll_req  in  1  one-cycle pulse: scroll up one row
busy  out  1  clear or scroll in progress
cursor_en  in  1  cursor display enable
cursor_col  in  $clog2(COLS)  cursor column
cursor_row  in  $clog2(ROWS)  cursor row (logical)
dot_counter  in  10  horizontal pixel index
scanline_counter  in  10  vertical line index
char_out  out  CHAR_W  code for current cell, 1-cycle latency
cursor_hit  out  1  current cell is cursor and blink phase on, aligned with char_out
in_view  out  1  current pixel lies inside the COLS x ROWS grid, aligned with char_out

Behaviour:
- Only clock is clk. Reset is asynchronous, active-low, on rst_n. Reset values: char_out=0, cursor_hit=0, in_view=0, top_row=0, blink counter=0, state=CLEAR, sweep index=0, busy=1, wr_ready=0.
- Physical row = (logical row + top_row) mod ROWS. Address = phys_row*COLS + col. RAM depth = COLS*ROWS.
- Display: col = dot_counter/CELL_W, row = scanline_counter/CELL_H.
  - If col<COLS and row<ROWS: char_out = RAM[addr] one clk later, and in_view=1.
  - Otherwise char_out=0 and in_view=0, also one clk later.
- cursor_hit (registered, same cycle as char_out) = cursor_en & in-range & col==cursor_col & row==cursor_row & blink phase.
- The display read port is never stalled. Reads during CLEAR/SCROLL return whatever the RAM currently holds.
- FSM states:
  - IDLE: wr_ready=1, busy=0.
    - clear_req -> CLEAR (index=0).
    - else scroll_req -> SCROLL: top_row increments mod ROWS that cycle; index = physical row of old top row * COLS.
    - clear_req has priority; a simultaneous scroll_req is dropped.
  - CLEAR: write FILL_CHAR to RAM[index] each cycle, index++. After index==COLS*ROWS-1 -> IDLE. Duration COLS*ROWS cycles.
  - SCROLL: write FILL_CHAR across the COLS cells of the vacated physical row (now the logical bottom row). Then -> IDLE. Duration COLS cycles.
  - In CLEAR/SCROLL: busy=1, wr_ready=0. clear_req/scroll_req are ignored, not queued.
- Writes: accepted only in IDLE on wr_valid & wr_ready. Stored next clk at logical (wr_row, wr_col).
  - Out-of-range coordinates complete the handshake but are discarded.
  - A write and a same-cycle clear_req/scroll_req: the write is stored first, then the FSM starts.
- Read/write same address same cycle: read returns old data (read-first).
- Blink counter is free-running and wraps, unaffected by FSM.
- Reset mid-clear or mid-scroll: the FSM restarts a full CLEAR and top_row returns to 0.

Decomposition:
- Shared package text_pkg holds:
  - state enum (IDLE, CLEAR, SCROLL)
  - default COLS/ROWS/CHAR_W constants
  - addr-width localparam helper
  - physical-row wrap function
- One sub-module, text_ram: simple dual-port RAM, one synchronous write port and one registered read port, read-first, no reset on contents.

Test Plan:
- Release reset -> busy=1 for exactly 3700 cycles (defaults), then busy=0 and wr_ready=1. Every cell reads 0.
- Write 0xA at (row 2, col 5); drive dot=40, scan=32 -> next cycle char_out=0xA, in_view=1.
- Fill row 0 with 0x1 and row 1 with 0x2, then pulse scroll_req -> busy for 100 cycles. Afterwards logical row 0 reads 0x2 and logical row 36 reads 0x0.
- cursor_en=1 at (row 3, col 7) with BLINK_DIV=4 -> cursor_hit toggles every 8 cycles on that cell only, and is always 0 elsewhere.
- dot=800 or scan=592 -> in_view=0 and char_out=0. A write to col 120 is accepted and leaves the memory unchanged.
- clear_req and scroll_req in the same cycle -> 3700-cycle clear, top_row unchanged. A scroll_req pulsed during busy has no effect.

Source files
------------

// File: rtl/text_pkg.sv
// Shared types and helpers for the character-cell text buffer.
package text_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        CLEAR  = 2'd1,
        SCROLL = 2'd2
    } state_t;

    localparam int DEF_COLS   = 100;
    localparam int DEF_ROWS   = 37;
    localparam int DEF_CHAR_W = 4;

    function automatic int addr_width(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

    // (row + offset) mod rows, assuming both operands are already below rows
    function automatic int unsigned wrap_row(input int unsigned row,
                                             input int unsigned offset,
                                             input int unsigned rows);
        int unsigned sum;
        sum = row + offset;
        return (sum >= rows) ? sum - rows : sum;
    endfunction

endpackage

// File: rtl/text_ram.sv
// Simple dual-port character store: one synchronous write port, one registered
// read port with read-first behaviour on address collision. Contents are not reset.
module text_ram #(
    parameter int DEPTH  = 3700,
    parameter int DATA_W = 4,
    parameter int ADDR_W = 12
) (
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [ADDR_W-1:0] raddr,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] mem [DEPTH];
    logic [DATA_W-1:0] rdata_reg;

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
        rdata_reg <= mem[raddr];
    end

    assign rdata = rdata_reg;

endmodule

// File: rtl/text_grid_buffer.sv
// Character-cell text buffer with clear/scroll engine, display read port and
// blinking cursor flag. Scrolling rotates top_row instead of moving data.
module text_grid_buffer
    import text_pkg::*;
#(
    parameter int                 COLS      = DEF_COLS,
    parameter int                 ROWS      = DEF_ROWS,
    parameter int                 CHAR_W    = DEF_CHAR_W,
    parameter int                 CELL_W    = 8,
    parameter int                 CELL_H    = 16,
    parameter logic [CHAR_W-1:0]  FILL_CHAR = '0,
    parameter int                 BLINK_DIV = 24
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     wr_valid,
    output logic                     wr_ready,
    input  logic [$clog2(COLS)-1:0]  wr_col,
    input  logic [$clog2(ROWS)-1:0]  wr_row,
    input  logic [CHAR_W-1:0]        wr_char,
    input  logic                     clear_req,
    input  logic                     scroll_req,
    output logic                     busy,
    input  logic                     cursor_en,
    input  logic [$clog2(COLS)-1:0]  cursor_col,
    input  logic [$clog2(ROWS)-1:0]  cursor_row,
    input  logic [9:0]               dot_counter,
    input  logic [9:0]               scanline_counter,
    output logic [CHAR_W-1:0]        char_out,
    output logic                     cursor_hit,
    output logic                     in_view
);

    localparam int COL_W      = $clog2(COLS);
    localparam int ROW_W      = $clog2(ROWS);
    localparam int DEPTH      = COLS * ROWS;
    localparam int ADDR_W     = addr_width(DEPTH);
    localparam int CELL_W_LOG = $clog2(CELL_W);
    localparam int CELL_H_LOG = $clog2(CELL_H);

    function automatic logic [ADDR_W-1:0] cell_addr(input logic [ROW_W-1:0] lrow,
                                                    input logic [COL_W-1:0] col,
                                                    input logic [ROW_W-1:0] top);
        int unsigned prow;
        prow = wrap_row(32'(lrow), 32'(top), ROWS);
        return ADDR_W'(prow * COLS + 32'(col));
    endfunction

    state_t              state_reg, state_next;
    logic [ADDR_W-1:0]   idx_reg, idx_next;
    logic [COL_W-1:0]    sweep_cnt_reg, sweep_cnt_next;
    logic [ROW_W-1:0]    top_row_reg, top_row_next;
    logic [BLINK_DIV-1:0] blink_cnt_reg;
    logic                in_view_reg;
    logic                cursor_hit_reg;

    logic                ram_we;
    logic [ADDR_W-1:0]   ram_waddr;
    logic [CHAR_W-1:0]   ram_wdata;
    logic [ADDR_W-1:0]   ram_raddr;
    logic [CHAR_W-1:0]   ram_rdata;

    logic [9:0]          disp_col;
    logic [9:0]          disp_row;
    logic                disp_in_range;
    logic                wr_in_range;

    assign disp_col      = dot_counter >> CELL_W_LOG;
    assign disp_row      = scanline_counter >> CELL_H_LOG;
    assign disp_in_range = (disp_col < 10'(COLS)) && (disp_row < 10'(ROWS));
    assign ram_raddr     = disp_in_range
                         ? cell_addr(disp_row[ROW_W-1:0], disp_col[COL_W-1:0], top_row_reg)
                         : '0;
    assign wr_in_range   = (int'(wr_col) < COLS) && (int'(wr_row) < ROWS);

    always_comb begin
        state_next     = state_reg;
        idx_next       = idx_reg;
        sweep_cnt_next = sweep_cnt_reg;
        top_row_next   = top_row_reg;
        ram_we         = 1'b0;
        ram_waddr      = idx_reg;
        ram_wdata      = FILL_CHAR;
        wr_ready       = 1'b0;
        busy           = 1'b1;
        case (state_reg)
            IDLE: begin
                wr_ready = 1'b1;
                busy     = 1'b0;
                // Out-of-range writes still handshake but never reach the RAM
                if (wr_valid && wr_in_range) begin
                    ram_we    = 1'b1;
                    ram_waddr = cell_addr(wr_row, wr_col, top_row_reg);
                    ram_wdata = wr_char;
                end
                if (clear_req) begin
                    state_next = CLEAR;
                    idx_next   = '0;
                end else if (scroll_req) begin
                    state_next     = SCROLL;
                    top_row_next   = ROW_W'(wrap_row(32'(top_row_reg), 32'd1, ROWS));
                    idx_next       = ADDR_W'(32'(top_row_reg) * COLS);
                    sweep_cnt_next = '0;
                end
            end
            CLEAR: begin
                ram_we   = 1'b1;
                idx_next = idx_reg + ADDR_W'(1);
                if (idx_reg == ADDR_W'(DEPTH - 1)) begin
                    state_next = IDLE;
                    idx_next   = '0;
                end
            end
            SCROLL: begin
                ram_we         = 1'b1;
                idx_next       = idx_reg + ADDR_W'(1);
                sweep_cnt_next = sweep_cnt_reg + COL_W'(1);
                if (sweep_cnt_reg == COL_W'(COLS - 1)) begin
                    state_next = IDLE;
                    idx_next   = '0;
                end
            end
            default: begin
                state_next = CLEAR;
                idx_next   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg     <= CLEAR;
            idx_reg       <= '0;
            sweep_cnt_reg <= '0;
            top_row_reg   <= '0;
        end else begin
            state_reg     <= state_next;
            idx_reg       <= idx_next;
            sweep_cnt_reg <= sweep_cnt_next;
            top_row_reg   <= top_row_next;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            blink_cnt_reg  <= '0;
            in_view_reg    <= 1'b0;
            cursor_hit_reg <= 1'b0;
        end else begin
            blink_cnt_reg  <= blink_cnt_reg + BLINK_DIV'(1);
            in_view_reg    <= disp_in_range;
            cursor_hit_reg <= cursor_en && disp_in_range
                           && (disp_col == 10'(cursor_col))
                           && (disp_row == 10'(cursor_row))
                           && blink_cnt_reg[BLINK_DIV-1];
        end
    end

    text_ram #(
        .DEPTH  (DEPTH),
        .DATA_W (CHAR_W),
        .ADDR_W (ADDR_W)
    ) u_ram (
        .clk   (clk),
        .we    (ram_we),
        .waddr (ram_waddr),
        .wdata (ram_wdata),
        .raddr (ram_raddr),
        .rdata (ram_rdata)
    );

    // RAM data is only meaningful for in-view cells; gate it with the aligned flag
    assign char_out   = in_view_reg ? ram_rdata : '0;
    assign in_view    = in_view_reg;
    assign cursor_hit = cursor_hit_reg;

endmodule

// File: tb/tb_text_grid_buffer.sv
// Scoreboard bench for text_grid_buffer: a logical-grid model predicts every
// display read; a monitor pops predictions as the registered outputs appear.
module tb_text_grid_buffer;

    localparam int COLS      = 100;
    localparam int ROWS      = 37;
    localparam int CHAR_W    = 4;
    localparam int BLINK_DIV = 4;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              wr_valid = 1'b0;
    logic              wr_ready;
    logic [6:0]        wr_col = '0;
    logic [5:0]        wr_row = '0;
    logic [CHAR_W-1:0] wr_char = '0;
    logic              clear_req = 1'b0;
    logic              scroll_req = 1'b0;
    logic              busy;
    logic              cursor_en = 1'b0;
    logic [6:0]        cursor_col = '0;
    logic [5:0]        cursor_row = '0;
    logic [9:0]        dot_counter = '0;
    logic [9:0]        scanline_counter = '0;
    logic [CHAR_W-1:0] char_out;
    logic              cursor_hit;
    logic              in_view;

    always #5 clk = ~clk;

    text_grid_buffer #(
        .COLS      (COLS),
        .ROWS      (ROWS),
        .CHAR_W    (CHAR_W),
        .CELL_W    (8),
        .CELL_H    (16),
        .FILL_CHAR (4'h0),
        .BLINK_DIV (BLINK_DIV)
    ) dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .wr_valid         (wr_valid),
        .wr_ready         (wr_ready),
        .wr_col           (wr_col),
        .wr_row           (wr_row),
        .wr_char          (wr_char),
        .clear_req        (clear_req),
        .scroll_req       (scroll_req),
        .busy             (busy),
        .cursor_en        (cursor_en),
        .cursor_col       (cursor_col),
        .cursor_row       (cursor_row),
        .dot_counter      (dot_counter),
        .scanline_counter (scanline_counter),
        .char_out         (char_out),
        .cursor_hit       (cursor_hit),
        .in_view          (in_view)
    );

    typedef struct {
        int          due;
        logic [3:0]  ch;
        logic        iv;
        logic        hit;
    } exp_t;

    exp_t        exp_q[$];
    logic [3:0]  grid [ROWS][COLS];
    int          cur_en_m, cur_row_m, cur_col_m;
    int          cyc;
    int          checks = 0;
    int          errors = 0;

    // Cycles since reset release; equals the DUT blink counter value at each edge
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) cyc <= 0;
        else        cyc <= cyc + 1;
    end

    task automatic chk(input string name, input int got, input int want);
        checks++;
        if (got != want) begin
            errors++;
            $display("FAIL %s got %0d expected %0d", name, got, want);
        end
    endtask

    task automatic clear_model();
        for (int r = 0; r < ROWS; r++)
            for (int c = 0; c < COLS; c++)
                grid[r][c] = 4'h0;
    endtask

    task automatic scroll_model();
        for (int r = 0; r < ROWS - 1; r++)
            for (int c = 0; c < COLS; c++)
                grid[r][c] = grid[r+1][c];
        for (int c = 0; c < COLS; c++)
            grid[ROWS-1][c] = 4'h0;
    endtask

    function automatic exp_t predict(input int dot, input int scan);
        exp_t e;
        int c, r;
        c     = dot / 8;
        r     = scan / 16;
        e.due = cyc + 1;
        e.iv  = (c < COLS) && (r < ROWS);
        e.ch  = e.iv ? grid[r][c] : 4'h0;
        e.hit = e.iv && (cur_en_m != 0) && (r == cur_row_m) && (c == cur_col_m)
                && (((cyc >> 3) & 1) == 1);
        return e;
    endfunction

    // Issue one display read at a negedge; result appears after the next posedge
    task automatic rd(input int dot, input int scan);
        dot_counter      = 10'(dot);
        scanline_counter = 10'(scan);
        exp_q.push_back(predict(dot, scan));
        @(negedge clk);
    endtask

    task automatic read_all();
        for (int r = 0; r < ROWS; r++)
            for (int c = 0; c < COLS; c++)
                rd(c * 8 + int'($urandom_range(7)), r * 16 + int'($urandom_range(15)));
    endtask

    task automatic wr(input int row, input int col, input logic [3:0] ch);
        wr_valid = 1'b1;
        wr_row   = 6'(row);
        wr_col   = 7'(col);
        wr_char  = ch;
        chk("wr_ready", int'(wr_ready), 1);
        @(negedge clk);
        wr_valid = 1'b0;
        if (row < ROWS && col < COLS) grid[row][col] = ch;
        $display("WR row=%0d col=%0d char=%h", row, col, ch);
    endtask

    // Write and display-read the same cell in one cycle: read sees the old value
    task automatic wr_rd_same(input int row, input int col, input logic [3:0] ch);
        wr_valid         = 1'b1;
        wr_row           = 6'(row);
        wr_col           = 7'(col);
        wr_char          = ch;
        dot_counter      = 10'(col * 8);
        scanline_counter = 10'(row * 16);
        exp_q.push_back(predict(col * 8, row * 16));
        @(negedge clk);
        wr_valid = 1'b0;
        grid[row][col] = ch;
        $display("WR+RD row=%0d col=%0d char=%h", row, col, ch);
    endtask

    // Called at the negedge after the request edge; counts busy cycles. At
    // iteration poke_at a scroll request and a write are attempted while busy.
    task automatic wait_idle(input string name, input int want, input int poke_at);
        int n;
        n = 0;
        while (busy === 1'b1 && n < 10000) begin
            scroll_req = (n == poke_at);
            wr_valid   = (n == poke_at);
            wr_row     = 6'd5;
            wr_col     = 7'd5;
            wr_char    = 4'hF;
            if (n == poke_at) chk({name, "_wr_ready_busy"}, int'(wr_ready), 0);
            n++;
            @(negedge clk);
        end
        scroll_req = 1'b0;
        wr_valid   = 1'b0;
        chk(name, n, want);
        chk({name, "_ready_after"}, int'(wr_ready), 1);
    endtask

    task automatic do_scroll(input bit with_wr, input int row, input int col,
                             input logic [3:0] ch);
        scroll_req = 1'b1;
        if (with_wr) begin
            wr_valid = 1'b1;
            wr_row   = 6'(row);
            wr_col   = 7'(col);
            wr_char  = ch;
        end
        @(negedge clk);
        scroll_req = 1'b0;
        wr_valid   = 1'b0;
        if (with_wr && row < ROWS && col < COLS) grid[row][col] = ch;
        scroll_model();
        $display("SCROLL with_wr=%0d", with_wr);
        wait_idle("scroll_busy", 100, -1);
    endtask

    task automatic set_cursor(input int en, input int row, input int col);
        cur_en_m   = en;
        cur_row_m  = row;
        cur_col_m  = col;
        cursor_en  = (en != 0);
        cursor_row = 6'(row);
        cursor_col = 7'(col);
    endtask

    task automatic check_reset_outputs(input string name);
        chk({name, "_busy"}, int'(busy), 1);
        chk({name, "_wr_ready"}, int'(wr_ready), 0);
        chk({name, "_char_out"}, int'(char_out), 0);
        chk({name, "_in_view"}, int'(in_view), 0);
        chk({name, "_cursor_hit"}, int'(cursor_hit), 0);
    endtask

    // Monitor: the display port presents a result every cycle; pop when due
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            while (exp_q.size() > 0 && exp_q[0].due <= cyc) begin
                e = exp_q.pop_front();
                checks++;
                if (e.due != cyc || char_out !== e.ch || in_view !== e.iv
                    || cursor_hit !== e.hit) begin
                    errors++;
                    $display("FAIL disp cyc=%0d got char=%h in_view=%b hit=%b expected char=%h in_view=%b hit=%b",
                             cyc, char_out, in_view, cursor_hit, e.ch, e.iv, e.hit);
                end
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        int op;
        set_cursor(0, 0, 0);
        clear_model();
        repeat (3) @(negedge clk);
        check_reset_outputs("reset");

        rst_n = 1'b1;
        $display("RESET released");
        wait_idle("reset_clear_busy", 3700, -1);
        read_all();

        // Directed write and read back
        wr(2, 5, 4'hA);
        rd(40, 32);
        rd(800, 0);
        rd(0, 592);
        rd(1023, 1023);
        rd(799, 591);

        // Out-of-range writes must not alias into neighbouring rows
        wr(0, 120, 4'h7);
        wr(36, 127, 4'h7);
        wr(40, 3, 4'h7);
        wr_rd_same(2, 5, 4'h3);
        rd(40, 32);

        for (int c = 0; c < COLS; c++) begin
            wr(0, c, 4'h1);
            wr(1, c, 4'h2);
        end
        do_scroll(1'b0, 0, 0, 4'h0);
        read_all();

        // Write coinciding with scroll lands before the row shift
        do_scroll(1'b1, 10, 20, 4'hC);
        rd(20 * 8, 9 * 16);

        // Cursor blink on one cell only
        wr(3, 7, 4'h5);
        set_cursor(1, 3, 7);
        for (int i = 0; i < 64; i++) begin
            if (i % 4 == 3) rd(8 * 8 + int'($urandom_range(7)), 3 * 16);
            else            rd(7 * 8 + int'($urandom_range(7)), 3 * 16 + int'($urandom_range(15)));
        end
        set_cursor(0, 3, 7);
        for (int i = 0; i < 16; i++) rd(7 * 8, 3 * 16);

        // Randomised mix of writes, reads, cursor moves and scrolls
        for (int i = 0; i < 600; i++) begin
            op = int'($urandom_range(39));
            if (op < 16) begin
                wr(int'($urandom_range(39)), int'($urandom_range(127)), 4'($urandom));
            end else if (op < 36) begin
                rd(int'($urandom_range(1023)), int'($urandom_range(1023)));
            end else if (op < 38) begin
                set_cursor(int'($urandom_range(1)), int'($urandom_range(ROWS - 1)),
                           int'($urandom_range(COLS - 1)));
            end else if (op == 38) begin
                do_scroll(1'b0, 0, 0, 4'h0);
            end else begin
                rd(int'($urandom_range(799)), int'($urandom_range(591)));
            end
        end
        set_cursor(1, 0, 0);
        read_all();

        // Clear beats a simultaneous scroll; requests during busy are ignored
        clear_req  = 1'b1;
        scroll_req = 1'b1;
        @(negedge clk);
        clear_req  = 1'b0;
        scroll_req = 1'b0;
        clear_model();
        $display("CLEAR+SCROLL requested together");
        wait_idle("clear_busy", 3700, 200);
        read_all();

        // Reset during a scroll restarts a full clear
        wr(4, 4, 4'h9);
        scroll_req = 1'b1;
        @(negedge clk);
        scroll_req = 1'b0;
        repeat (50) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check_reset_outputs("midscroll_reset");
        @(negedge clk);
        rst_n = 1'b1;
        clear_model();
        $display("RESET released after mid-scroll reset");
        wait_idle("midscroll_clear_busy", 3700, -1);
        wr(0, 0, 4'hE);
        read_all();

        repeat (3) @(negedge clk);
        chk("scoreboard_drained", exp_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
